l1pa_regfile_loader: RTL and testbench

L1PA_REGFILE_LOADER -- requirements
Module: l1pa_regfile_loader

---
 rtl/l1pa_regfile_loader.sv | 101 ++++++++++
 tb/tb_l1pa_regfile_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1pa_regfile_loader.sv
// l1pa_regfile_loader: loads a run of pages into a register file through a valid/ready handshake.
// Ports: sys_clk/rstn (clock, sync active-low reset), start_i/page_cnt_i (load request and page count),
// abort_i (cancel load), pg_data_i/pg_valid_i/pg_ready_o (page stream), regType0_* (register-file write port),
// busy_o (LOAD state), done_o (completion pulse), err_o (illegal start pulse).
module l1pa_regfile_loader #(
    parameter int L1PA_REGFILE_PAGE_NUM   = 8,
    parameter int L1PA_REGFILE_PAGE_WIDTH = 16,
    parameter int L1PA_REGFILE_ADDR_WIDTH = 3
) (
    input  logic                               sys_clk,
    input  logic                               rstn,
    input  logic                               start_i,
    input  logic [L1PA_REGFILE_ADDR_WIDTH:0]   page_cnt_i,
    input  logic                               abort_i,
    input  logic [L1PA_REGFILE_PAGE_WIDTH-1:0] pg_data_i,
    input  logic                               pg_valid_i,
    output logic                               pg_ready_o,
    output logic [L1PA_REGFILE_ADDR_WIDTH-1:0] regType0_waddr_o,
    output logic [L1PA_REGFILE_PAGE_WIDTH-1:0] regType0_wdata_o,
    output logic                               regType0_we_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o
);
    localparam int AW = L1PA_REGFILE_ADDR_WIDTH;
    localparam int DW = L1PA_REGFILE_PAGE_WIDTH;
    localparam logic [AW:0] MAX_CNT = (AW+1)'(L1PA_REGFILE_PAGE_NUM);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t          r_state;
    logic [AW:0]     r_cnt;
    logic [AW:0]     r_lat;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic            r_we;
    logic            r_done;
    logic            r_err;
    logic            w_start_ok;
    logic            w_hs;
    logic            w_last;

    assign w_start_ok = (page_cnt_i != '0) && (page_cnt_i <= MAX_CNT);
    assign busy_o     = r_state == S_LOAD;
    // abort wins over the handshake so no page is taken in the abort cycle
    assign pg_ready_o = busy_o && !abort_i;
    assign w_hs       = pg_valid_i && pg_ready_o;
    assign w_last     = r_cnt == r_lat - 1'b1;

    assign regType0_waddr_o = r_waddr;
    assign regType0_wdata_o = r_wdata;
    assign regType0_we_o    = r_we;
    assign done_o           = r_done;
    assign err_o            = r_err;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lat   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i && w_start_ok) begin
                        r_lat   <= page_cnt_i;
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end else if (start_i) begin
                        r_err <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (abort_i) begin
                        r_state <= S_IDLE;
                    end else if (w_hs) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_cnt[AW-1:0];
                        r_wdata <= pg_data_i;
                        // final page: done_o rises together with its write strobe
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1pa_regfile_loader.sv
// tb_l1pa_regfile_loader: randomized and directed self-checking bench for l1pa_regfile_loader.
module tb_l1pa_regfile_loader;
    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  page_cnt_i = '0;
    logic        abort_i = 1'b0;
    logic [15:0] pg_data_i = '0;
    logic        pg_valid_i = 1'b0;
    logic        pg_ready_o;
    logic [2:0]  regType0_waddr_o;
    logic [15:0] regType0_wdata_o;
    logic        regType0_we_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_n = 0;
    int done_n = 0;
    int err_n = 0;
    int          wa_q[$];
    logic [15:0] wd_q[$];
    logic        wdn_q[$];
    int          wc_q[$];
    int          exp_a[$];
    logic [15:0] exp_d[$];

    l1pa_regfile_loader dut (
        .sys_clk(sys_clk), .rstn(rstn), .start_i(start_i), .page_cnt_i(page_cnt_i),
        .abort_i(abort_i), .pg_data_i(pg_data_i), .pg_valid_i(pg_valid_i), .pg_ready_o(pg_ready_o),
        .regType0_waddr_o(regType0_waddr_o), .regType0_wdata_o(regType0_wdata_o),
        .regType0_we_o(regType0_we_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        cyc++;
        if (regType0_we_o) begin
            wa_q.push_back(int'(regType0_waddr_o));
            wd_q.push_back(regType0_wdata_o);
            wdn_q.push_back(done_o);
            wc_q.push_back(cyc);
        end
        busy_n += int'(busy_o);
        done_n += int'(done_o);
        err_n  += int'(err_o);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wdn_q.delete(); wc_q.delete();
        exp_a.delete(); exp_d.delete();
        busy_n = 0; done_n = 0; err_n = 0;
    endtask

    task automatic start_load(input int n);
        start_i = 1'b1;
        page_cnt_i = 4'(n);
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++;
        if ({regType0_we_o, regType0_waddr_o, regType0_wdata_o, done_o, err_o, busy_o, pg_ready_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h done=%b err=%b busy=%b ready=%b, required all 0",
                     regType0_we_o, regType0_waddr_o, regType0_wdata_o, done_o, err_o, busy_o, pg_ready_o);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_full_load();
        clear_mon();
        start_load(8);
        for (int i = 0; i < 8; i++) begin
            pg_valid_i = 1'b1;
            pg_data_i = 16'(i);
            tick();
        end
        pg_valid_i = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (wa_q.size() != 8) begin
            failures++;
            $display("FAIL full_count: got %0d writes, required 8", wa_q.size());
        end
        for (int i = 0; i < wa_q.size() && i < 8; i++) begin
            checks++;
            if (wa_q[i] != i || wd_q[i] !== 16'(i) || wc_q[i] != wc_q[0] + i || wdn_q[i] !== (i == 7)) begin
                failures++;
                $display("FAIL full_write%0d: addr=%0d data=%h done=%b cyc_off=%0d, required addr=%0d data=%h done=%b cyc_off=%0d",
                         i, wa_q[i], wd_q[i], wdn_q[i], wc_q[i] - wc_q[0], i, i, i == 7, i);
            end
        end
        checks++;
        if (busy_n != 8 || done_n != 1) begin
            failures++;
            $display("FAIL full_busy_done: busy=%0d done=%0d, required busy=8 done=1", busy_n, done_n);
        end
    endtask

    task automatic test_gaps();
        clear_mon();
        start_load(3);
        for (int i = 0; i < 5; i++) begin
            pg_valid_i = (i % 2) == 0;
            pg_data_i = 16'(16'hA0 + i);
            tick();
        end
        pg_valid_i = 1'b0;
        tick(); tick();
        checks++;
        if (wa_q.size() != 3) begin
            failures++;
            $display("FAIL gaps_count: got %0d writes, required 3", wa_q.size());
        end
        for (int i = 0; i < wa_q.size() && i < 3; i++) begin
            checks++;
            if (wa_q[i] != i || wd_q[i] !== 16'(16'hA0 + 2 * i)) begin
                failures++;
                $display("FAIL gaps_write%0d: addr=%0d data=%h, required addr=%0d data=%h", i, wa_q[i], wd_q[i], i, 16'hA0 + 2 * i);
            end
        end
        checks++;
        if (done_n != 1) begin
            failures++;
            $display("FAIL gaps_done: got %0d done pulses, required 1", done_n);
        end
    endtask

    task automatic test_illegal();
        clear_mon();
        start_load(0);
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL illegal_zero_err: err=%b, required 1", err_o);
        end
        tick();
        start_load(9);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL illegal_nine_err: err=%b busy=%b, required err=1 busy=0", err_o, busy_o);
        end
        pg_valid_i = 1'b1;
        tick(); tick();
        pg_valid_i = 1'b0;
        tick();
        checks++;
        if (err_n != 2 || busy_n != 0 || wa_q.size() != 0) begin
            failures++;
            $display("FAIL illegal_summary: err=%0d busy=%0d writes=%0d, required 2 0 0", err_n, busy_n, wa_q.size());
        end
    endtask

    task automatic test_abort();
        clear_mon();
        start_load(5);
        for (int i = 0; i < 2; i++) begin
            pg_valid_i = 1'b1;
            pg_data_i = 16'(16'h50 + i);
            tick();
        end
        pg_data_i = 16'h52;
        abort_i = 1'b1;
        #1;
        checks++;
        if (pg_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready: ready=%b, required 0", pg_ready_o);
        end
        tick();
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || regType0_we_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: busy=%b we=%b, required 0 0", busy_o, regType0_we_o);
        end
        tick(); tick();
        pg_valid_i = 1'b0;
        tick();
        checks++;
        if (wa_q.size() != 2 || done_n != 0 || wa_q[0] != 0 || wa_q[1] != 1 || wd_q[1] !== 16'h51) begin
            failures++;
            $display("FAIL abort_writes: writes=%0d done=%0d, required 2 writes to 0,1 and no done", wa_q.size(), done_n);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        start_load(8);
        for (int i = 0; i < 4; i++) begin
            pg_valid_i = 1'b1;
            pg_data_i = 16'(16'h70 + i);
            tick();
        end
        rstn = 1'b0;
        tick();
        checks++;
        if ({regType0_we_o, regType0_waddr_o, regType0_wdata_o, done_o, err_o, busy_o, pg_ready_o} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: we=%b addr=%0d data=%h done=%b err=%b busy=%b ready=%b, required all 0",
                     regType0_we_o, regType0_waddr_o, regType0_wdata_o, done_o, err_o, busy_o, pg_ready_o);
        end
        rstn = 1'b1;
        pg_valid_i = 1'b0;
        tick();
        clear_mon();
        start_load(2);
        pg_valid_i = 1'b1;
        pg_data_i = 16'hBEEF; tick();
        pg_data_i = 16'hCAFE; tick();
        pg_valid_i = 1'b0;
        tick(); tick();
        checks++;
        if (wa_q.size() != 2 || wa_q[0] != 0 || wa_q[1] != 1 || wd_q[0] !== 16'hBEEF || wd_q[1] !== 16'hCAFE || done_n != 1) begin
            failures++;
            $display("FAIL midreset_reload: writes=%0d done=%0d, required writes 0:BEEF 1:CAFE and 1 done", wa_q.size(), done_n);
        end
    endtask

    task automatic test_ignored_start();
        clear_mon();
        start_load(4);
        for (int i = 0; i < 4; i++) begin
            pg_valid_i = 1'b1;
            pg_data_i = 16'(16'h30 + i);
            start_i = (i == 1);
            page_cnt_i = 4'd1;
            tick();
        end
        pg_valid_i = 1'b0;
        start_i = 1'b1;
        page_cnt_i = 4'd3;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (wa_q.size() != 4 || busy_n != 4 || done_n != 1) begin
            failures++;
            $display("FAIL ignored_start: writes=%0d busy=%0d done=%0d, required 4 4 1", wa_q.size(), busy_n, done_n);
        end
        for (int i = 0; i < wa_q.size() && i < 4; i++) begin
            checks++;
            if (wa_q[i] != i || wd_q[i] !== 16'(16'h30 + i)) begin
                failures++;
                $display("FAIL ignored_write%0d: addr=%0d data=%h, required addr=%0d data=%h", i, wa_q[i], wd_q[i], i, 16'h30 + i);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int n = $urandom_range(1, 8);
            int accepted = 0;
            int model_busy = 0;
            int guard = 0;
            clear_mon();
            start_load(n);
            while (accepted < n && guard < 400) begin
                logic v = 1'($urandom_range(0, 1));
                logic [15:0] d = 16'($urandom);
                pg_valid_i = v;
                pg_data_i = d;
                model_busy++;
                guard++;
                if (v) begin
                    exp_a.push_back(accepted);
                    exp_d.push_back(d);
                    accepted++;
                end
                tick();
            end
            pg_valid_i = 1'b0;
            tick(); tick();
            checks++;
            if (wa_q.size() != exp_a.size() || busy_n != model_busy || done_n != 1) begin
                failures++;
                $display("FAIL rand%0d_summary: writes=%0d busy=%0d done=%0d, required %0d %0d 1",
                         it, wa_q.size(), busy_n, done_n, exp_a.size(), model_busy);
            end
            for (int i = 0; i < wa_q.size() && i < exp_a.size(); i++) begin
                checks++;
                if (wa_q[i] != exp_a[i] || wd_q[i] !== exp_d[i] || wdn_q[i] !== (i == n - 1)) begin
                    failures++;
                    $display("FAIL rand%0d_write%0d: addr=%0d data=%h done=%b, required addr=%0d data=%h done=%b",
                             it, i, wa_q[i], wd_q[i], wdn_q[i], exp_a[i], exp_d[i], i == n - 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_illegal();
        test_abort();
        test_reset_mid();
        test_ignored_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
